// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the multi-channel SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_DONE
    } state_e;

    localparam int unsigned DEF_DATA_W = 32;
    // Wait-state counts are limited to 1..7, so three bits always suffice.
    localparam int unsigned TIMER_W    = $clog2(8);

    function automatic int unsigned byte_lanes(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/sram_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    input  logic              en,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    logic            found;
    logic [CH_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = CH_W'((32'(ptr) + i) % NUM_CH);
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM among NUM_CH requestors with round-robin grant,
// programmable read/write wait states and a one-cycle completion pulse.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned RD_CYCLES = 2,
    parameter int unsigned WR_CYCLES = 2
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic [NUM_CH-1:0]                       io_req_valid,
    output logic [NUM_CH-1:0]                       io_req_ready,
    input  logic [NUM_CH-1:0]                       io_req_we,
    input  logic [NUM_CH*ADDR_W-1:0]                io_req_addr,
    input  logic [NUM_CH*DATA_W-1:0]                io_req_wdata,
    input  logic [NUM_CH*byte_lanes(DATA_W)-1:0]    io_req_wmask,
    output logic [NUM_CH-1:0]                       io_rsp_valid,
    output logic [DATA_W-1:0]                       io_rsp_rdata,
    inout  wire  [DATA_W-1:0]                       ram_data,
    output logic [ADDR_W-1:0]                       ram_addr,
    output logic [byte_lanes(DATA_W)-1:0]           ram_be_n,
    output logic                                    ram_ce_n,
    output logic                                    ram_oe_n,
    output logic                                    ram_we_n
);

    localparam int unsigned LANES = byte_lanes(DATA_W);
    localparam int unsigned CH_W  = $clog2(NUM_CH);

    state_e              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [CH_W-1:0]     ptr_q, ptr_nxt;
    logic [CH_W-1:0]     ch_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [LANES-1:0]    wmask_q, wmask_src;
    logic                run_q;
    logic                drive_q;

    logic [NUM_CH-1:0]   grant;
    logic [CH_W-1:0]     grant_idx;
    logic                accept;
    logic                sample;

    logic                ce_n_d, oe_n_d, we_n_d, drive_d;
    logic [LANES-1:0]    be_n_d;
    logic [NUM_CH-1:0]   rsp_d;

    // run_q keeps ready low while reset is asserted, whatever the masters drive.
    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr (
        .req       (io_req_valid),
        .ptr       (ptr_q),
        .en        (run_q && (state_q == ST_IDLE)),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign io_req_ready = grant;
    assign accept       = |grant;
    assign ptr_nxt      = (32'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + CH_W'(1);
    assign wmask_src    = accept ? io_req_wmask[grant_idx*LANES +: LANES] : wmask_q;
    assign sample       = (state_q == ST_RD) && (timer_q == '0);
    assign ram_data     = drive_q ? wdata_q : {DATA_W{1'bz}};

    // Next state, then SRAM controls decoded from the state being entered so
    // that every pin comes straight from a flop.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        be_n_d  = '1;
        drive_d = 1'b0;
        rsp_d   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (io_req_we[grant_idx]) begin
                        state_d = ST_WR_SETUP;
                        timer_d = TIMER_W'(WR_CYCLES - 1);
                    end else begin
                        state_d = ST_RD;
                        timer_d = TIMER_W'(RD_CYCLES - 1);
                    end
                end
            end
            ST_RD: begin
                if (timer_q == '0) state_d = ST_DONE;
                else               timer_d = timer_q - TIMER_W'(1);
            end
            ST_WR_SETUP: state_d = ST_WR_PULSE;
            ST_WR_PULSE: begin
                if (timer_q == '0) state_d = ST_WR_HOLD;
                else               timer_d = timer_q - TIMER_W'(1);
            end
            ST_WR_HOLD: state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_RD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = '0;
            end
            ST_WR_SETUP, ST_WR_HOLD: begin
                ce_n_d  = 1'b0;
                be_n_d  = ~wmask_src;
                drive_d = 1'b1;
            end
            ST_WR_PULSE: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                be_n_d  = ~wmask_src;
                drive_d = 1'b1;
            end
            ST_DONE: rsp_d = NUM_CH'(1) << ch_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            ptr_q        <= '0;
            ch_q         <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            run_q        <= 1'b0;
            drive_q      <= 1'b0;
            ram_addr     <= '0;
            ram_be_n     <= '1;
            ram_ce_n     <= 1'b1;
            ram_oe_n     <= 1'b1;
            ram_we_n     <= 1'b1;
            io_rsp_valid <= '0;
            io_rsp_rdata <= '0;
        end else begin
            run_q        <= 1'b1;
            state_q      <= state_d;
            timer_q      <= timer_d;
            drive_q      <= drive_d;
            ram_be_n     <= be_n_d;
            ram_ce_n     <= ce_n_d;
            ram_oe_n     <= oe_n_d;
            ram_we_n     <= we_n_d;
            io_rsp_valid <= rsp_d;
            if (accept) begin
                ptr_q    <= ptr_nxt;
                ch_q     <= grant_idx;
                ram_addr <= io_req_addr[grant_idx*ADDR_W +: ADDR_W];
                wdata_q  <= io_req_wdata[grant_idx*DATA_W +: DATA_W];
                wmask_q  <= io_req_wmask[grant_idx*LANES +: LANES];
            end
            if (sample) io_rsp_rdata <= ram_data;
        end
    end

endmodule
